// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle control sequencer for a LEGv8-style datapath
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   opcode[10:0]             Instruction[31:21], valid from DECODE onward
//   zero                     ALU zero flag, used for CBZ/CBNZ
//   mem_ready                memory acknowledge for the current request
//   mem_req/mem_we/mem_sel   memory request, write enable, address select (0=PC, 1=ALU)
//   ir_write, pc_write       instruction register and PC load strobes
//   pc_src                   PC source (0=PC+4, 1=branch target)
//   reg2loc, alu_src, alu_op register/ALU operand and operation selects
//   reg_write, mem_to_reg    register-file write strobe and write-back source
//   state[2:0]               current state code
//   illegal, timeout         sticky error flags
//   retired[31:0]            completed-instruction counter
module multicycle_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_RTYPE = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_CBZ   = 3'd4,
        C_CBNZ  = 3'd5,
        C_B     = 3'd6
    } class_t;

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_t        state_q;
    state_t        next_state;
    class_t        cls_q;
    class_t        dec_class;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          set_illegal;
    logic          set_timeout;
    logic          retire_inc;
    logic          cls_r2l;
    logic          dec_r2l;

    assign state = state_q;

    always_comb begin
        dec_class = C_NONE;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_class = C_RTYPE;
            11'b11111000010: dec_class = C_LOAD;
            11'b11111000000: dec_class = C_STORE;
            11'b10110100???: dec_class = C_CBZ;
            11'b10110101???: dec_class = C_CBNZ;
            11'b000101?????: dec_class = C_B;
            default:         dec_class = C_NONE;
        endcase
    end

    // The latched class is not available until DECODE ends, so DECODE itself
    // selects reg2loc from the live decode; later states use the latched copy.
    assign dec_r2l = (dec_class == C_STORE) || (dec_class == C_CBZ) || (dec_class == C_CBNZ);
    assign cls_r2l = (cls_q == C_STORE) || (cls_q == C_CBZ) || (cls_q == C_CBNZ);

    // Fires on the cycle the counter would reach TIMEOUT, i.e. after TIMEOUT
    // unanswered request cycles.
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        next_state  = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg2loc     = 1'b0;
        alu_src     = 1'b0;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire_inc  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    set_timeout = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_DECODE: begin
                reg2loc = dec_r2l;
                case (dec_class)
                    C_RTYPE, C_LOAD, C_STORE: next_state = S_EXEC;
                    C_CBZ, C_CBNZ, C_B:       next_state = S_BRANCH;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_ERROR;
                    end
                endcase
            end
            S_EXEC: begin
                reg2loc = cls_r2l;
                if (cls_q == C_RTYPE) begin
                    alu_op     = 2'b10;
                    next_state = S_WB;
                end else begin
                    alu_src    = 1'b1;
                    next_state = S_MEM;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cls_q == C_STORE);
                alu_src = 1'b1;
                reg2loc = cls_r2l;
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire_inc = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout_hit) begin
                    set_timeout = 1'b1;
                    next_state  = S_ERROR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LOAD);
                reg2loc    = cls_r2l;
                retire_inc = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_op     = 2'b01;
                pc_src     = 1'b1;
                reg2loc    = cls_r2l;
                pc_write   = (cls_q == C_B) || ((cls_q == C_CBZ) && zero) ||
                             ((cls_q == C_CBNZ) && !zero);
                retire_inc = 1'b1;
                next_state = S_FETCH;
            end
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            cls_q    <= C_NONE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
            retired  <= 32'd0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE) begin
                cls_q <= dec_class;
            end
            // A self-loop only happens while waiting on memory, so any state
            // change restarts the count for the next request.
            if (next_state != state_q) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (retire_inc) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

    localparam int TO = 255;

    // Control vector bit order:
    // {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op[1:0], reg_write, mem_to_reg}
    localparam logic [11:0] K_IDLE   = 12'h000;
    localparam logic [11:0] K_FWAIT  = 12'h800;
    localparam logic [11:0] K_FRDY   = 12'h980;
    localparam logic [11:0] K_DR2L   = 12'h020;
    localparam logic [11:0] K_EXR    = 12'h008;
    localparam logic [11:0] K_EXL    = 12'h010;
    localparam logic [11:0] K_EXS    = 12'h030;
    localparam logic [11:0] K_MEML   = 12'hA10;
    localparam logic [11:0] K_MEMS   = 12'hE30;
    localparam logic [11:0] K_WBR    = 12'h002;
    localparam logic [11:0] K_WBL    = 12'h003;
    localparam logic [11:0] K_BCBZT  = 12'h0E4;
    localparam logic [11:0] K_BCBNZN = 12'h064;
    localparam logic [11:0] K_BB     = 12'h0C4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100011;
    localparam logic [10:0] OP_CBNZ = 11'b10110101001;
    localparam logic [10:0] OP_B    = 11'b00010110101;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] ctrl;
        logic        ill;
        logic        to;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src;
    logic        reg2loc, alu_src, reg_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        illegal, timeout;
    logic [31:0] retired;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    multicycle_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
        .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb.pop_front();
            a = '{state, {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg2loc,
                          alu_src, alu_op, reg_write, mem_to_reg}, illegal, timeout, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got st=%0d ctrl=%03h ill=%0b to=%0b ret=%0d want st=%0d ctrl=%03h ill=%0b to=%0b ret=%0d",
                         $time, a.st, a.ctrl, a.ill, a.to, a.ret, e.st, e.ctrl, e.ill, e.to, e.ret);
            end
        end
    end

    task automatic step(input logic rst, input logic [10:0] op, input logic z, input logic rdy,
                        input logic [2:0] st, input logic [11:0] ctrl, input logic ill,
                        input logic to, input logic [31:0] ret);
        exp_t e;
        reset     = rst;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        e = '{st, ctrl, ill, to, ret};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        // reset state, reset still held
        step(1, 0, 0, 0, 3'd0, K_FWAIT, 0, 0, 0);

        // ADD, immediate ack
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 0);
        step(0, OP_ADD,  0, 0, 3'd1, K_IDLE, 0, 0, 0);
        step(0, OP_ADD,  0, 0, 3'd2, K_EXR,  0, 0, 0);
        step(0, OP_ADD,  0, 0, 3'd4, K_WBR,  0, 0, 0);

        // LDUR, three wait cycles in MEM
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 1);
        step(0, OP_LDUR, 0, 0, 3'd1, K_IDLE, 0, 0, 1);
        step(0, OP_LDUR, 0, 0, 3'd2, K_EXL,  0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, OP_LDUR, 0, 0, 3'd3, K_MEML, 0, 0, 1);
        step(0, OP_LDUR, 0, 1, 3'd3, K_MEML, 0, 0, 1);
        step(0, OP_LDUR, 0, 0, 3'd4, K_WBL,  0, 0, 1);

        // STUR, fetch waits twice; retires on the MEM ack, no WB
        step(0, 0,       0, 0, 3'd0, K_FWAIT, 0, 0, 2);
        step(0, 0,       0, 0, 3'd0, K_FWAIT, 0, 0, 2);
        step(0, 0,       0, 1, 3'd0, K_FRDY,  0, 0, 2);
        step(0, OP_STUR, 0, 0, 3'd1, K_DR2L,  0, 0, 2);
        step(0, OP_STUR, 0, 0, 3'd2, K_EXS,   0, 0, 2);
        step(0, OP_STUR, 0, 1, 3'd3, K_MEMS,  0, 0, 2);

        // CBZ taken (zero=1)
        step(0, 0,       1, 1, 3'd0, K_FRDY,  0, 0, 3);
        step(0, OP_CBZ,  1, 0, 3'd1, K_DR2L,  0, 0, 3);
        step(0, OP_CBZ,  1, 0, 3'd5, K_BCBZT, 0, 0, 3);

        // CBNZ not taken (zero=1)
        step(0, 0,       1, 1, 3'd0, K_FRDY,   0, 0, 4);
        step(0, OP_CBNZ, 1, 0, 3'd1, K_DR2L,   0, 0, 4);
        step(0, OP_CBNZ, 1, 0, 3'd5, K_BCBNZN, 0, 0, 4);

        // B always taken
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 5);
        step(0, OP_B,    0, 0, 3'd1, K_IDLE, 0, 0, 5);
        step(0, OP_B,    0, 0, 3'd5, K_BB,   0, 0, 5);

        // ack arrives on the last allowed wait cycle: ready wins over timeout
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 3'd0, K_FWAIT, 0, 0, 6);
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 6);
        step(0, OP_ADD,  0, 0, 3'd1, K_IDLE, 0, 0, 6);
        step(0, OP_ADD,  0, 0, 3'd2, K_EXR,  0, 0, 6);
        step(0, OP_ADD,  0, 0, 3'd4, K_WBR,  0, 0, 6);

        // reset abandons a pending load access; fetch restarts next cycle
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 7);
        step(0, OP_LDUR, 0, 0, 3'd1, K_IDLE, 0, 0, 7);
        step(0, OP_LDUR, 0, 0, 3'd2, K_EXL,  0, 0, 7);
        step(0, OP_LDUR, 0, 0, 3'd3, K_MEML, 0, 0, 7);
        step(1, OP_LDUR, 0, 1, 3'd3, K_MEML, 0, 0, 7);

        // fetch timeout after TO unanswered cycles
        for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 3'd0, K_FWAIT, 0, 0, 0);
        step(0, 0,       0, 1, 3'd7, K_IDLE, 0, 1, 0);
        step(0, 0,       0, 0, 3'd7, K_IDLE, 0, 1, 0);
        step(1, 0,       0, 0, 3'd7, K_IDLE, 0, 1, 0);

        // illegal opcode 0x000
        step(0, 0,       0, 1, 3'd0, K_FRDY, 0, 0, 0);
        step(0, 0,       0, 0, 3'd1, K_IDLE, 0, 0, 0);
        step(0, 0,       0, 1, 3'd7, K_IDLE, 1, 0, 0);
        step(0, OP_ADD,  0, 1, 3'd7, K_IDLE, 1, 0, 0);
        step(1, 0,       0, 0, 3'd7, K_IDLE, 1, 0, 0);
        step(0, 0,       0, 0, 3'd0, K_FWAIT, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
